// File: rtl/stream_reducer.sv
// Folds a stream of MSB-first byte-assembled operands with add/mul/max/xor.
// Latency: 2 cycles after the last byte (WIDTH_P+1 for mul); bytes are held off via ready_o outside COLLECT.
module stream_reducer #(
  parameter int WIDTH_P = 32,
  parameter int LEN_W_P = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [LEN_W_P-1:0] len_i,
  input  logic               valid_i,
  input  logic [7:0]         data_i,
  output logic               ready_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [WIDTH_P-1:0] result_o,
  output logic               overflow_o
);

  localparam int NB  = WIDTH_P / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam int MBW = $clog2(WIDTH_P);
  localparam logic [BCW-1:0] NB_LAST  = BCW'(NB - 1);
  localparam logic [MBW-1:0] MB_LAST  = MBW'(WIDTH_P - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, DONE} state_t;

  state_t                r_state;
  logic [1:0]            r_op;
  logic [LEN_W_P-1:0]    r_rem;
  logic [BCW-1:0]        r_bcnt;
  logic [MBW-1:0]        r_mbit;
  logic [WIDTH_P-1:0]    r_opnd;
  logic [WIDTH_P-1:0]    r_acc;
  logic [2*WIDTH_P-1:0]  r_prod;
  logic                  r_ovf;
  logic [WIDTH_P-1:0]    r_result;
  logic                  r_ovf_out;
  logic                  r_done;

  logic                  w_hs;
  logic [WIDTH_P-1:0]    w_opnd_nxt;
  logic [WIDTH_P:0]      w_add_sum;
  logic [WIDTH_P:0]      w_mul_sum;
  logic [2*WIDTH_P-1:0]  w_prod_nxt;
  logic [LEN_W_P-1:0]    w_rem_nxt;
  logic [WIDTH_P-1:0]    w_res;
  logic                  w_ovf_set;
  logic                  w_step_done;
  logic                  w_ovf_nxt;

  assign w_hs       = valid_i && (r_state == COLLECT);
  assign w_opnd_nxt = (r_opnd << 8) | WIDTH_P'(data_i);
  assign w_add_sum  = {1'b0, r_acc} + {1'b0, r_opnd};
  // Low half of r_prod holds the multiplier; the accumulator is the multiplicand.
  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH_P-1:WIDTH_P]} + (r_prod[0] ? {1'b0, r_acc} : '0);
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH_P-1:1]};
  assign w_rem_nxt  = (r_rem != '0) ? r_rem - LEN_W_P'(1) : '0;
  assign w_ovf_nxt  = r_ovf | w_ovf_set;

  always_comb begin
    w_res       = r_acc;
    w_ovf_set   = 1'b0;
    w_step_done = 1'b1;
    case (r_op)
      2'd0: begin
        w_res     = w_add_sum[WIDTH_P-1:0];
        w_ovf_set = w_add_sum[WIDTH_P];
      end
      2'd1: begin
        w_res       = w_prod_nxt[WIDTH_P-1:0];
        w_ovf_set   = |w_prod_nxt[2*WIDTH_P-1:WIDTH_P];
        w_step_done = (r_mbit == MB_LAST);
      end
      2'd2:    w_res = (r_opnd > r_acc) ? r_opnd : r_acc;
      default: w_res = r_acc ^ r_opnd;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_rem     <= '0;
      r_bcnt    <= '0;
      r_mbit    <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_prod    <= '0;
      r_ovf     <= 1'b0;
      r_result  <= '0;
      r_ovf_out <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start_i) begin
          r_op      <= op_i;
          r_rem     <= len_i;
          r_ovf     <= 1'b0;
          r_ovf_out <= 1'b0;
          r_bcnt    <= '0;
          r_acc     <= (op_i == 2'd1) ? WIDTH_P'(1) : '0;
          r_state   <= (len_i == '0) ? DONE : COLLECT;
        end
        COLLECT: if (w_hs) begin
          r_opnd <= w_opnd_nxt;
          if (r_bcnt == NB_LAST) begin
            r_bcnt  <= '0;
            r_mbit  <= '0;
            r_prod  <= {{WIDTH_P{1'b0}}, w_opnd_nxt};
            r_state <= COMPUTE;
          end else begin
            r_bcnt <= r_bcnt + BCW'(1);
          end
        end
        COMPUTE: if (w_step_done) begin
          r_acc <= w_res;
          r_ovf <= w_ovf_nxt;
          r_rem <= w_rem_nxt;
          if (w_rem_nxt == '0) begin
            r_done    <= 1'b1;
            r_result  <= w_res;
            r_ovf_out <= w_ovf_nxt;
            r_state   <= DONE;
          end else begin
            r_state <= COLLECT;
          end
        end else begin
          r_prod <= w_prod_nxt;
          r_mbit <= r_mbit + MBW'(1);
        end
        DONE: begin
          // Arriving straight from IDLE (len 0) spends one extra cycle before the pulse.
          if (r_done) begin
            r_state <= IDLE;
          end else begin
            r_done    <= 1'b1;
            r_result  <= r_acc;
            r_ovf_out <= r_ovf;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ready_o    = (r_state == COLLECT);
  assign busy_o     = (r_state != IDLE);
  assign done_o     = r_done;
  assign result_o   = r_result;
  assign overflow_o = r_ovf_out;

endmodule

// File: tb/tb_stream_reducer.sv
// Directed bench for stream_reducer at WIDTH_P=32 with hand-computed expectations.
module tb_stream_reducer;
  localparam int W  = 32;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [LW-1:0] len = '0;
  logic          valid = 1'b0;
  logic [7:0]    data = '0;
  logic          ready, busy, done, ovf;
  logic [W-1:0]  result;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt;
  bit saw_rdy;

  always #5 clk = ~clk;

  stream_reducer #(.WIDTH_P(W), .LEN_W_P(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .len_i(len),
    .valid_i(valid), .data_i(data), .ready_o(ready), .busy_o(busy),
    .done_o(done), .result_o(result), .overflow_o(ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [1:0] o, input logic [LW-1:0] l, input bit with_byte);
    start = 1'b1; op = o; len = l; valid = with_byte; data = 8'hEE;
    @(negedge clk);
    start = 1'b0; valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    valid = 1'b1; data = d;
    while (!ready && t < 100) begin @(negedge clk); t++; end
    if (!ready) check("ready_timeout", {63'b0, ready}, 64'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic send_operand(input logic [31:0] v, input bit gap);
    for (int b = 3; b >= 0; b--) begin
      if (gap && b != 3) @(negedge clk);
      send_byte(v[8*b +: 8]);
    end
  endtask

  task automatic wait_done(output int c, output bit sr);
    c = 0; sr = 1'b0;
    while (!done && c < 200) begin
      @(negedge clk); c++;
      if (ready) sr = 1'b1;
    end
    if (!done) check("done_timeout", {63'b0, done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_done", done, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // mul 2*3*7
    do_start(2'd1, 16'd3, 1'b0);
    send_operand(32'd2, 1'b0);
    send_operand(32'd3, 1'b0);
    send_operand(32'd7, 1'b0);
    check("mul_rdy_compute", ready, 0);
    wait_done(cnt, saw_rdy);
    check("mul_latency", cnt, W);
    check("mul_rdy_seen", saw_rdy, 0);
    check("mul_result", result, 32'h2A);
    check("mul_ovf", ovf, 0);
    @(negedge clk);
    check("mul_done_once", done, 0);
    check("mul_idle", busy, 0);

    // mul overflow: 0x10000 * 0x10000 = 2^32
    do_start(2'd1, 16'd2, 1'b0);
    send_operand(32'h0001_0000, 1'b0);
    send_operand(32'h0001_0000, 1'b0);
    wait_done(cnt, saw_rdy);
    check("mulovf_result", result, 32'h0);
    check("mulovf_ovf", ovf, 1);
    @(negedge clk);

    // add with carry-out
    do_start(2'd0, 16'd2, 1'b0);
    check("add_ovf_cleared", ovf, 0);
    send_operand(32'hFFFF_FFFF, 1'b0);
    send_operand(32'h0000_0002, 1'b0);
    wait_done(cnt, saw_rdy);
    check("add_latency", cnt, 1);
    check("add_result", result, 32'h1);
    check("add_ovf", ovf, 1);
    @(negedge clk);

    // max
    do_start(2'd2, 16'd3, 1'b0);
    check("max_ovf_cleared", ovf, 0);
    check("max_result_hold", result, 32'h1);
    send_operand(32'd5, 1'b0);
    send_operand(32'h8000_0000, 1'b0);
    send_operand(32'd9, 1'b0);
    wait_done(cnt, saw_rdy);
    check("max_result", result, 32'h8000_0000);
    check("max_ovf", ovf, 0);
    @(negedge clk);

    // xor len 0, then start coinciding with done is ignored
    do_start(2'd3, 16'd0, 1'b0);
    check("len0_busy", busy, 1);
    check("len0_no_early_done", done, 0);
    check("len0_ready", ready, 0);
    wait_done(cnt, saw_rdy);
    check("len0_latency", cnt, 1);
    check("len0_rdy_seen", saw_rdy, 0);
    check("len0_result", result, 32'h0);
    start = 1'b1; op = 2'd0; len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    check("start_at_done_ignored", busy, 0);
    check("done_cleared", done, 0);

    // add len 1 with gapped bytes; valid alongside start must not be consumed
    do_start(2'd0, 16'd1, 1'b1);
    send_operand(32'h1234_5678, 1'b1);
    check("gap_rdy_compute", ready, 0);
    wait_done(cnt, saw_rdy);
    check("gap_latency", cnt, 1);
    check("gap_rdy_seen", saw_rdy, 0);
    check("gap_result", result, 32'h1234_5678);
    @(negedge clk);

    // reset during mul compute
    do_start(2'd1, 16'd1, 1'b0);
    send_operand(32'd3, 1'b0);
    repeat (5) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_result", result, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ready, 0);
    check("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("midrst_spurious_done", cnt, 0);
    do_start(2'd0, 16'd1, 1'b0);
    send_operand(32'hA, 1'b0);
    wait_done(cnt, saw_rdy);
    check("post_rst_result", result, 32'hA);
    check("post_rst_ovf", ovf, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
